if_id_stage_reg: RTL and testbench

//   IF/ID pipeline register. Sits directly downstream of the program-counter register.

---
 rtl/if_id_stage_reg.sv | 93 +++++++++
 tb/tb_if_id_stage_reg.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline register: captures fetch PC/instruction, tags illegal fetch addresses with AdEL,
// and carries the delay-slot and valid bits into decode. Supports stall (hold) and flush (bubble).
module if_id_stage_reg #(
    parameter logic [31:0] TEXT_BASE = 32'h0000_3000,
    parameter logic [31:0] TEXT_END  = 32'h0000_4FFC,
    parameter logic [4:0]  EXC_ADEL  = 5'd4,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] pc_f,
    input  logic [31:0] instr_f,
    input  logic        id_is_branch,
    output logic [31:0] pc_d,
    output logic [31:0] instr_d,
    output logic [31:0] pc8_d,
    output logic        valid_d,
    output logic        bd_d,
    output logic        exc_valid_d,
    output logic [4:0]  exc_code_d
);

    logic [31:0] pc_id_q, pc_id_d;
    logic [31:0] instr_id_q, instr_id_d;
    logic        valid_id_q, valid_id_d;
    logic        bd_id_q, bd_id_d;
    logic        exc_valid_id_q, exc_valid_id_d;
    logic [4:0]  exc_code_id_q, exc_code_id_d;
    logic        fetch_bad;

    // Unsigned compares; a misaligned PC faults even when inside the text segment.
    assign fetch_bad = (pc_f[1:0] != 2'b00) | (pc_f < TEXT_BASE) | (pc_f > TEXT_END);

    always_comb begin
        pc_id_d        = pc_id_q;
        instr_id_d     = instr_id_q;
        valid_id_d     = valid_id_q;
        bd_id_d        = bd_id_q;
        exc_valid_id_d = exc_valid_id_q;
        exc_code_id_d  = exc_code_id_q;
        if (flush) begin
            pc_id_d        = pc_f;
            instr_id_d     = NOP_WORD;
            valid_id_d     = 1'b0;
            bd_id_d        = 1'b0;
            exc_valid_id_d = 1'b0;
            exc_code_id_d  = 5'd0;
        end else if (!stall) begin
            // A faulting fetch stays valid so its PC can reach CP0 as EPC.
            pc_id_d    = pc_f;
            valid_id_d = 1'b1;
            bd_id_d    = id_is_branch;
            if (fetch_bad) begin
                instr_id_d     = NOP_WORD;
                exc_valid_id_d = 1'b1;
                exc_code_id_d  = EXC_ADEL;
            end else begin
                instr_id_d     = instr_f;
                exc_valid_id_d = 1'b0;
                exc_code_id_d  = 5'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_id_q        <= TEXT_BASE;
            instr_id_q     <= NOP_WORD;
            valid_id_q     <= 1'b0;
            bd_id_q        <= 1'b0;
            exc_valid_id_q <= 1'b0;
            exc_code_id_q  <= 5'd0;
        end else begin
            pc_id_q        <= pc_id_d;
            instr_id_q     <= instr_id_d;
            valid_id_q     <= valid_id_d;
            bd_id_q        <= bd_id_d;
            exc_valid_id_q <= exc_valid_id_d;
            exc_code_id_q  <= exc_code_id_d;
        end
    end

    assign pc_d        = pc_id_q;
    assign instr_d     = instr_id_q;
    assign pc8_d       = pc_id_q + 32'd8;
    assign valid_d     = valid_id_q;
    assign bd_d        = bd_id_q;
    assign exc_valid_d = exc_valid_id_q;
    assign exc_code_d  = exc_code_id_q;

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Testbench for if_id_stage_reg: directed scenarios with literal expectations, then random
// stimulus, all checked every cycle against a behavioural model of the IF/ID register.
module tb_if_id_stage_reg;

    localparam logic [31:0] BASE = 32'h0000_3000;
    localparam logic [31:0] TEND = 32'h0000_4FFC;

    logic        clk = 1'b0;
    logic        reset, stall, flush, id_is_branch;
    logic [31:0] pc_f, instr_f;
    logic [31:0] pc_d, instr_d, pc8_d;
    logic        valid_d, bd_d, exc_valid_d;
    logic [4:0]  exc_code_d;

    int checks = 0;
    int errors = 0;

    if_id_stage_reg dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .pc_f(pc_f), .instr_f(instr_f), .id_is_branch(id_is_branch),
        .pc_d(pc_d), .instr_d(instr_d), .pc8_d(pc8_d), .valid_d(valid_d),
        .bd_d(bd_d), .exc_valid_d(exc_valid_d), .exc_code_d(exc_code_d)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the decode stage should see, from the fetch rules.
    logic        m_ok = 1'b0;
    logic [31:0] m_pc, m_instr;
    logic        m_valid, m_bd, m_exc;
    logic [4:0]  m_code;

    function automatic bit legal_fetch(input logic [31:0] a);
        return (a % 4 == 0) && (a >= BASE) && (a <= TEND);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_ok = 1'b1;
            m_pc = BASE; m_instr = 32'h0; m_valid = 1'b0; m_bd = 1'b0; m_exc = 1'b0; m_code = 5'd0;
        end else if (flush) begin
            m_pc = pc_f; m_instr = 32'h0; m_valid = 1'b0; m_bd = 1'b0; m_exc = 1'b0; m_code = 5'd0;
        end else if (!stall) begin
            m_pc    = pc_f;
            m_valid = 1'b1;
            m_bd    = id_is_branch;
            m_exc   = !legal_fetch(pc_f);
            m_instr = m_exc ? 32'h0 : instr_f;
            m_code  = m_exc ? 5'd4 : 5'd0;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("cyc_pc", pc_d, m_pc);
            chk("cyc_instr", instr_d, m_instr);
            chk("cyc_pc8", pc8_d, m_pc + 32'd8);
            chk("cyc_valid", {31'b0, valid_d}, {31'b0, m_valid});
            chk("cyc_bd", {31'b0, bd_d}, {31'b0, m_bd});
            chk("cyc_exc", {31'b0, exc_valid_d}, {31'b0, m_exc});
            if (m_exc) chk("cyc_code", {27'b0, exc_code_d}, {27'b0, m_code});
        end
    end

    // Drive one cycle's inputs at a negedge, then wait for the next negedge.
    task automatic step(input logic r, input logic s, input logic f,
                        input logic [31:0] pc, input logic [31:0] ins, input logic br);
        reset = r; stall = s; flush = f; pc_f = pc; instr_f = ins; id_is_branch = br;
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_pc();
        case ($urandom_range(0, 5))
            0: return BASE + 32'(4 * $urandom_range(0, 32'h7FF));
            1: return TEND;
            2: return TEND + 32'd4;
            3: return BASE - 32'd4;
            4: return BASE + 32'(4 * $urandom_range(0, 32'h7FF)) + 32'($urandom_range(1, 3));
            default: return $urandom;
        endcase
    endfunction

    logic [31:0] held_instr;

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; pc_f = 32'h0; instr_f = 32'h0; id_is_branch = 1'b0;
        @(negedge clk);
        step(1, 0, 0, 32'h1234_5678, 32'hDEAD_BEEF, 1);
        chk("rst_pc", pc_d, 32'h3000);
        chk("rst_instr", instr_d, 32'h0);
        chk("rst_pc8", pc8_d, 32'h3008);
        chk("rst_valid", {31'b0, valid_d}, 32'h0);
        chk("rst_exc", {31'b0, exc_valid_d}, 32'h0);

        step(0, 0, 0, 32'h3004, 32'h2408_0001, 1);
        chk("ld_pc", pc_d, 32'h3004);
        chk("ld_instr", instr_d, 32'h2408_0001);
        chk("ld_pc8", pc8_d, 32'h300C);
        chk("ld_valid", {31'b0, valid_d}, 32'h1);
        chk("ld_bd", {31'b0, bd_d}, 32'h1);

        step(0, 0, 0, 32'h3002, 32'h1111_1111, 0);
        chk("mis_exc", {31'b0, exc_valid_d}, 32'h1);
        chk("mis_code", {27'b0, exc_code_d}, 32'h4);
        chk("mis_instr", instr_d, 32'h0);
        chk("mis_valid", {31'b0, valid_d}, 32'h1);
        step(0, 0, 0, 32'h5000, 32'h2222_2222, 0);
        chk("hi_exc", {31'b0, exc_valid_d}, 32'h1);
        chk("hi_code", {27'b0, exc_code_d}, 32'h4);
        chk("hi_instr", instr_d, 32'h0);
        step(0, 0, 0, 32'h4FFC, 32'h3333_3333, 0);
        chk("end_exc", {31'b0, exc_valid_d}, 32'h0);
        chk("end_instr", instr_d, 32'h3333_3333);
        step(0, 0, 0, 32'h2FFC, 32'h4444_4444, 0);
        chk("lo_exc", {31'b0, exc_valid_d}, 32'h1);

        step(0, 0, 0, 32'h3010, 32'h5555_5555, 1);
        held_instr = instr_d;
        chk("st_load", pc_d, 32'h3010);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 32'h3040 + 32'(4 * i), $urandom, 0);
            chk("st_pc", pc_d, 32'h3010);
            chk("st_instr", instr_d, held_instr);
            chk("st_pc8", pc8_d, 32'h3018);
        end

        step(0, 1, 1, 32'h3020, 32'h6666_6666, 1);
        chk("fl_valid", {31'b0, valid_d}, 32'h0);
        chk("fl_instr", instr_d, 32'h0);
        chk("fl_bd", {31'b0, bd_d}, 32'h0);
        chk("fl_exc", {31'b0, exc_valid_d}, 32'h0);
        chk("fl_pc", pc_d, 32'h3020);

        step(0, 0, 0, 32'h3001, 32'h7777_7777, 0);
        chk("f2_exc1", {31'b0, exc_valid_d}, 32'h1);
        step(0, 0, 1, 32'h3024, 32'h8888_8888, 0);
        chk("f2_exc0", {31'b0, exc_valid_d}, 32'h0);
        step(0, 1, 0, 32'h3028, 32'h9999_9999, 0);
        step(1, 1, 0, 32'h302C, 32'hAAAA_AAAA, 0);
        chk("rst_stall_pc", pc_d, 32'h3000);
        chk("rst_stall_valid", {31'b0, valid_d}, 32'h0);

        step(0, 0, 0, 32'hFFFF_FFFC, 32'hBBBB_BBBB, 0);
        chk("wrap_pc8", pc8_d, 32'h0000_0004);
        chk("wrap_exc", {31'b0, exc_valid_d}, 32'h1);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                 rand_pc(), $urandom, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
